// File: rtl/nvme_prp_pkg.sv
// Shared types and derived-size helpers for the PRP list builder.
package nvme_prp_pkg;

  localparam int unsigned PRP_W      = 64;
  localparam int unsigned SLOT_MAX_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DESC = 2'd2
  } prp_state_e;

  typedef struct packed {
    logic [PRP_W-1:0]      prp1;
    logic [PRP_W-1:0]      prp2;
    logic [SLOT_MAX_W-1:0] slot;
  } prp_desc_t;

  // Pages per block minus the one carried directly in PRP1.
  function automatic int prp_entries(input int unsigned block_exp, input int unsigned page_exp);
    return int'((64'(1) << block_exp) >> page_exp) - 1;
  endfunction

  function automatic int unsigned prp_slot_w(input int unsigned slots);
    return (slots <= 1) ? 1 : $clog2(slots);
  endfunction

  // 8-byte entries per page.
  function automatic int unsigned prp_idx_w(input int unsigned page_exp);
    return page_exp - 3;
  endfunction

endpackage

// File: rtl/prp_slot_alloc.sv
// PRP list slot bitmap: lowest-free allocation, release, bad-release flag.
module prp_slot_alloc
  import nvme_prp_pkg::*;
#(
  parameter int unsigned LIST_SLOTS = 4,
  parameter int unsigned SLOT_W     = 2
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              alloc_en,
  output logic [SLOT_W-1:0] alloc_id_c,
  output logic              free_any_c,
  input  logic              slot_free,
  input  logic [SLOT_W-1:0] slot_free_id,
  output logic              err_free
);

  logic [LIST_SLOTS-1:0] busy_q;
  logic [LIST_SLOTS-1:0] alloc_mask;
  logic [LIST_SLOTS-1:0] rel_mask;
  logic                  rel_busy;

  // Priority encoder: scan downwards so the lowest free slot wins.
  always_comb begin
    alloc_id_c = '0;
    free_any_c = ~&busy_q;
    for (int i = LIST_SLOTS - 1; i >= 0; i--) begin
      if (!busy_q[i]) alloc_id_c = SLOT_W'(i);
    end
  end

  // Release and allocation masks; release of an idle slot is ignored.
  always_comb begin
    rel_busy   = slot_free && busy_q[slot_free_id];
    rel_mask   = rel_busy ? (LIST_SLOTS'(1) << slot_free_id) : '0;
    alloc_mask = alloc_en ? (LIST_SLOTS'(1) << alloc_id_c) : '0;
  end

  // Bitmap update and sticky bad-release flag.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      busy_q   <= '0;
      err_free <= 1'b0;
    end else begin
      busy_q <= (busy_q & ~rel_mask) | alloc_mask;
      if (slot_free && !busy_q[slot_free_id]) err_free <= 1'b1;
    end
  end

endmodule

// File: rtl/prp_list_builder.sv
// Pops PRP entries for pages 2..N of a block into a list slot and emits a command descriptor.
module prp_list_builder
  import nvme_prp_pkg::*;
#(
  parameter int unsigned DATA_WIDTH        = 64,
  parameter int unsigned BLOCK_SIZE_EXP    = 16,
  parameter int unsigned DDR_PAGE_SIZE_EXP = 12,
  parameter int unsigned LIST_SLOTS        = 4,
  parameter logic [63:0] PRP_LIST_BASE     = 64'h10_0800_0000,
  localparam int unsigned SLOT_W           = prp_slot_w(LIST_SLOTS),
  localparam int unsigned IDX_W            = prp_idx_w(DDR_PAGE_SIZE_EXP)
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [63:0]             req_prp1,
  input  logic                    fifo_empty,
  output logic                    fifo_pop,
  input  logic [DATA_WIDTH-1:0]   data_from_fifo,
  output logic                    list_wr_en,
  output logic [SLOT_W+IDX_W-1:0] list_wr_addr,
  output logic [63:0]             list_wr_data,
  output logic                    desc_valid,
  input  logic                    desc_ready,
  output logic [63:0]             desc_prp1,
  output logic [63:0]             desc_prp2,
  output logic [SLOT_W-1:0]       desc_slot,
  input  logic                    slot_free,
  input  logic [SLOT_W-1:0]       slot_free_id,
  output logic                    err_unaligned,
  output logic                    err_free
);

  localparam int                ENTRIES  = prp_entries(BLOCK_SIZE_EXP, DDR_PAGE_SIZE_EXP);
  localparam int unsigned       OFF_W    = DDR_PAGE_SIZE_EXP;
  localparam bit                SINGLE   = (ENTRIES == 1);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(ENTRIES - 1);

  // Reject block/page ratios that leave no list entries or overflow one page.
  if (ENTRIES < 1 || ENTRIES > (1 << IDX_W)) begin : g_cfg_err
    $error("prp_list_builder: ENTRIES out of range for page size");
  end

  prp_state_e        state, state_nxt;
  logic [63:0]       prp1_q;
  logic [SLOT_W-1:0] slot_q;
  logic [IDX_W-1:0]  idx_q;
  prp_desc_t         desc_q;
  logic [SLOT_W-1:0] alloc_id;
  logic              free_any;
  logic              accept;
  logic              last_pop;
  logic              desc_hs;
  logic [63:0]       list_prp2;
  logic              slot_pad_unused;

  prp_slot_alloc #(
    .LIST_SLOTS (LIST_SLOTS),
    .SLOT_W     (SLOT_W)
  ) u_slot_alloc (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .alloc_en     (accept),
    .alloc_id_c   (alloc_id),
    .free_any_c   (free_any),
    .slot_free    (slot_free),
    .slot_free_id (slot_free_id),
    .err_free     (err_free)
  );

  assign accept    = req_valid && req_ready;
  assign last_pop  = fifo_pop && (idx_q == LAST_IDX);
  assign desc_hs   = (state == DESC) && desc_ready;
  assign list_prp2 = PRP_LIST_BASE + (64'(slot_q) << DDR_PAGE_SIZE_EXP);

  assign desc_prp1 = desc_q.prp1;
  assign desc_prp2 = desc_q.prp2;
  assign desc_slot = desc_q.slot[SLOT_W-1:0];
  // Slot field is zero-extended to the widest supported slot id.
  assign slot_pad_unused = |desc_q.slot;

  // State register.
  always_ff @(posedge aclk) begin
    if (!aresetn) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next state plus the handshake strobes that must respond within the cycle.
  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    fifo_pop  = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready = free_any;
        if (req_valid && free_any) state_nxt = FILL;
      end
      FILL: begin
        fifo_pop = !fifo_empty;
        if (!fifo_empty && (idx_q == LAST_IDX)) state_nxt = DESC;
      end
      DESC: begin
        if (desc_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Command context, list writes, descriptor and alignment flag.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      prp1_q        <= '0;
      slot_q        <= '0;
      idx_q         <= '0;
      list_wr_en    <= 1'b0;
      list_wr_addr  <= '0;
      list_wr_data  <= '0;
      desc_valid    <= 1'b0;
      desc_q        <= '0;
      err_unaligned <= 1'b0;
    end else begin
      list_wr_en <= fifo_pop && !SINGLE;
      if (accept) begin
        prp1_q <= req_prp1;
        slot_q <= alloc_id;
        idx_q  <= '0;
      end
      if (fifo_pop) begin
        idx_q <= idx_q + IDX_W'(1);
        if (!SINGLE) begin
          list_wr_addr <= {slot_q, idx_q};
          list_wr_data <= 64'(data_from_fifo);
        end
        if (data_from_fifo[OFF_W-1:0] != '0) err_unaligned <= 1'b1;
      end
      if (last_pop) begin
        desc_valid  <= 1'b1;
        desc_q.prp1 <= prp1_q;
        desc_q.prp2 <= SINGLE ? 64'(data_from_fifo) : list_prp2;
        desc_q.slot <= SLOT_MAX_W'(slot_q);
      end else if (desc_hs) begin
        desc_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_prp_list_builder.sv
// Directed bench for prp_list_builder with a show-ahead FIFO model and write/descriptor logs.
module tb_prp_list_builder;

  localparam int ENTRIES = 15;
  localparam int IDX_W   = 9;
  localparam logic [63:0] LIST_BASE = 64'h10_0800_0000;

  logic        aclk;
  logic        aresetn;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_prp1;
  logic        fifo_empty;
  logic        fifo_pop;
  logic [63:0] data_from_fifo;
  logic        list_wr_en;
  logic [10:0] list_wr_addr;
  logic [63:0] list_wr_data;
  logic        desc_valid;
  logic        desc_ready;
  logic [63:0] desc_prp1;
  logic [63:0] desc_prp2;
  logic [1:0]  desc_slot;
  logic        slot_free;
  logic [1:0]  slot_free_id;
  logic        err_unaligned;
  logic        err_free;

  prp_list_builder dut (
    .aclk           (aclk),
    .aresetn        (aresetn),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_prp1       (req_prp1),
    .fifo_empty     (fifo_empty),
    .fifo_pop       (fifo_pop),
    .data_from_fifo (data_from_fifo),
    .list_wr_en     (list_wr_en),
    .list_wr_addr   (list_wr_addr),
    .list_wr_data   (list_wr_data),
    .desc_valid     (desc_valid),
    .desc_ready     (desc_ready),
    .desc_prp1      (desc_prp1),
    .desc_prp2      (desc_prp2),
    .desc_slot      (desc_slot),
    .slot_free      (slot_free),
    .slot_free_id   (slot_free_id),
    .err_unaligned  (err_unaligned),
    .err_free       (err_free)
  );

  typedef struct {
    logic [63:0] prp1;
    bit          free_en;
    int          free_id;
    bit          gap;
    int          hold;
    int          exp_slot;
    logic [63:0] exp_prp2;
  } vec_t;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // FIFO source model (main thread loads, driver presents).
  logic [63:0] src [0:63];
  int          src_len   = 0;
  int          pop_base  = 0;
  bit          gap_mode  = 0;

  // Monitor state.
  int          pop_cnt      = 0;
  int          pop_empty_err = 0;
  int          desc_cnt     = 0;
  logic        desc_prev    = 1'b0;
  logic [63:0] wlog_addr[$];
  logic [63:0] wlog_data[$];
  int          wlog_cyc[$];

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  always @(posedge aclk) cyc++;

  // Show-ahead FIFO head driven just after each edge.
  always @(posedge aclk) begin
    int hd;
    #2;
    hd = pop_cnt - pop_base;
    if (hd < src_len) data_from_fifo = src[hd];
    fifo_empty = (hd >= src_len) || (gap_mode && ($urandom_range(0, 1) == 0));
  end

  // Observe pops, list writes and descriptor launches mid-cycle.
  always @(negedge aclk) begin
    if (fifo_pop) begin
      pop_cnt++;
      if (fifo_empty) pop_empty_err++;
    end
    if (list_wr_en) begin
      wlog_addr.push_back(64'(list_wr_addr));
      wlog_data.push_back(list_wr_data);
      wlog_cyc.push_back(cyc);
    end
    if (desc_valid && !desc_prev) desc_cnt++;
    desc_prev = desc_valid;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge aclk);
    #3;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic free_slot(input int id);
    slot_free    = 1'b1;
    slot_free_id = 2'(id);
    tick();
    slot_free    = 1'b0;
    slot_free_id = 2'd0;
  endtask

  task automatic load_src(input logic [63:0] prp1, input int bad_k);
    for (int k = 0; k < ENTRIES; k++) src[k] = prp1 + 64'(k + 1) * 64'h1000;
    if (bad_k >= 0) src[bad_k] = src[bad_k] | 64'h8;
    src_len  = ENTRIES;
    pop_base = pop_cnt;
  endtask

  task automatic run_txn(input logic [63:0] prp1, input bit gap, input int hold,
                         input int exp_slot, input logic [63:0] exp_prp2,
                         input int bad_k, input bit lat_chk);
    int n;
    int t0;
    int wb;
    int db;
    n = 0;
    while (!req_ready && n < 50) begin tick(); n++; end
    chk("req_ready_before", 64'(req_ready), 64'd1);
    load_src(prp1, bad_k);
    gap_mode = gap;
    wb = wlog_addr.size();
    db = desc_cnt;
    req_valid = 1'b1;
    req_prp1  = prp1;
    t0 = cyc;
    tick();
    req_valid = 1'b0;
    req_prp1  = '0;
    n = 0;
    while (!desc_valid && n < 200) begin tick(); n++; end
    chk("desc_valid", 64'(desc_valid), 64'd1);
    if (lat_chk) chk("desc_latency", 64'(cyc - t0), 64'd16);
    chk("desc_prp1", desc_prp1, prp1);
    chk("desc_prp2", desc_prp2, exp_prp2);
    chk("desc_slot", 64'(desc_slot), 64'(exp_slot));
    for (int h = 0; h < hold; h++) begin
      tick();
      chk("hold_valid", 64'(desc_valid), 64'd1);
      chk("hold_prp2", desc_prp2, exp_prp2);
      chk("hold_no_pop", 64'(fifo_pop), 64'd0);
      chk("hold_not_ready", 64'(req_ready), 64'd0);
    end
    desc_ready = 1'b1;
    tick();
    desc_ready = 1'b0;
    gap_mode   = 1'b0;
    chk("desc_drop", 64'(desc_valid), 64'd0);
    if (hold > 0) chk("idle_after_hs", 64'(req_ready), 64'd1);
    chk("wr_count", 64'(wlog_addr.size() - wb), 64'd15);
    if (lat_chk && wlog_cyc.size() > wb) chk("first_wr_cyc", 64'(wlog_cyc[wb] - t0), 64'd2);
    for (int k = 0; k < ENTRIES; k++) begin
      if (wb + k < wlog_addr.size()) begin
        chk("wr_addr", wlog_addr[wb + k], 64'((exp_slot << IDX_W) | k));
        chk("wr_data", wlog_data[wb + k], src[k]);
      end
    end
    chk("pop_while_empty", 64'(pop_empty_err), 64'd0);
    chk("desc_count", 64'(desc_cnt - db), 64'd1);
  endtask

  initial begin
    vec_t vecs [6];
    int   n;
    int   pb;
    int   db;

    vecs[0] = '{64'h10_0000_0000, 1'b0, 0, 1'b0, 0,  0, 64'h10_0800_0000};
    vecs[1] = '{64'h10_0001_0000, 1'b0, 0, 1'b1, 0,  1, 64'h10_0800_1000};
    vecs[2] = '{64'h10_0002_0000, 1'b0, 0, 1'b0, 10, 2, 64'h10_0800_2000};
    vecs[3] = '{64'h10_0003_0000, 1'b0, 0, 1'b0, 0,  3, 64'h10_0800_3000};
    vecs[4] = '{64'h10_0004_0000, 1'b1, 2, 1'b0, 0,  2, 64'h10_0800_2000};
    vecs[5] = '{64'h10_0005_0000, 1'b1, 0, 1'b1, 0,  0, 64'h10_0800_0000};

    aresetn        = 1'b0;
    req_valid      = 1'b0;
    req_prp1       = '0;
    fifo_empty     = 1'b1;
    data_from_fifo = '0;
    desc_ready     = 1'b0;
    slot_free      = 1'b0;
    slot_free_id   = 2'd0;

    // Reset state.
    repeat (3) tick();
    chk("rst_wr_en", 64'(list_wr_en), 64'd0);
    chk("rst_desc_valid", 64'(desc_valid), 64'd0);
    chk("rst_desc_prp2", desc_prp2, 64'd0);
    chk("rst_err_unaligned", 64'(err_unaligned), 64'd0);
    chk("rst_err_free", 64'(err_free), 64'd0);
    chk("rst_fifo_pop", 64'(fifo_pop), 64'd0);
    aresetn = 1'b1;
    tick();
    chk("post_rst_ready", 64'(req_ready), 64'd1);

    // Table: back-to-back allocation, gaps, descriptor stall, release and reuse.
    for (int i = 0; i < 6; i++) begin
      if (vecs[i].free_en) begin
        chk("all_busy_not_ready", 64'(req_ready), 64'd0);
        free_slot(vecs[i].free_id);
      end
      run_txn(vecs[i].prp1, vecs[i].gap, vecs[i].hold, vecs[i].exp_slot,
              vecs[i].exp_prp2, -1, !vecs[i].gap);
    end
    repeat (3) tick();
    chk("full_not_ready", 64'(req_ready), 64'd0);
    chk("no_err_unaligned", 64'(err_unaligned), 64'd0);

    // Release every slot; all are busy so no error.
    for (int s = 0; s < 4; s++) free_slot(s);
    chk("busy_free_no_err", 64'(err_free), 64'd0);

    // Fifth entry misaligned: flagged, still written verbatim.
    run_txn(64'h10_0000_0000, 1'b0, 0, 0, 64'h10_0800_0000, 4, 1'b1);
    chk("err_unaligned_set", 64'(err_unaligned), 64'd1);
    free_slot(0);
    chk("free_busy_ok", 64'(err_free), 64'd0);
    free_slot(3);
    chk("free_idle_err", 64'(err_free), 64'd1);
    repeat (3) tick();
    chk("err_unaligned_sticky", 64'(err_unaligned), 64'd1);
    chk("err_free_sticky", 64'(err_free), 64'd1);

    // Reset at the 7th pop abandons the command.
    load_src(64'h10_0000_0000, -1);
    pb = pop_cnt;
    db = desc_cnt;
    req_valid = 1'b1;
    req_prp1  = 64'h10_0000_0000;
    tick();
    req_valid = 1'b0;
    req_prp1  = '0;
    n = 0;
    while (!(fifo_pop && (pop_cnt - pb == 6)) && n < 50) begin tick(); n++; end
    chk("seventh_pop_seen", 64'(fifo_pop && (pop_cnt - pb == 6)), 64'd1);
    chk("pre_rst_addr", 64'(list_wr_addr), 64'd5);
    aresetn = 1'b0;
    tick();
    chk("mid_rst_wr_en", 64'(list_wr_en), 64'd0);
    chk("mid_rst_wr_addr", 64'(list_wr_addr), 64'd0);
    chk("mid_rst_wr_data", list_wr_data, 64'd0);
    chk("mid_rst_desc_valid", 64'(desc_valid), 64'd0);
    chk("mid_rst_desc_prp1", desc_prp1, 64'd0);
    chk("mid_rst_desc_prp2", desc_prp2, 64'd0);
    chk("mid_rst_desc_slot", 64'(desc_slot), 64'd0);
    chk("mid_rst_err_unaligned", 64'(err_unaligned), 64'd0);
    chk("mid_rst_err_free", 64'(err_free), 64'd0);
    chk("mid_rst_fifo_pop", 64'(fifo_pop), 64'd0);
    tick();
    aresetn = 1'b1;
    repeat (20) tick();
    chk("no_partial_desc", 64'(desc_cnt - db), 64'd0);
    run_txn(64'h10_0007_0000, 1'b0, 0, 0, 64'h10_0800_0000, -1, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/prp_list_builder.md
Name: prp_list_builder

Overview:
- Downstream consumer of the PRP entry FIFO (prp_fifo_control).
- For each block-sized transfer request, pops the PRP entries for pages 2..N of the block from the FIFO and writes them into one page-sized PRP list slot in list RAM.
- Emits a command descriptor (PRP1, PRP2, slot id) to the SQ entry builder.
- Slots are reserved until the completion path releases them.

Parameters:
- DATA_WIDTH, 64, width of FIFO entries and list RAM data.
- BLOCK_SIZE_EXP, 16, log2 of transfer size in bytes.
- DDR_PAGE_SIZE_EXP, 12, log2 of memory page size in bytes.
- LIST_SLOTS, 4, number of PRP list pages; power of 2, 2..16.
- PRP_LIST_BASE, 64'h10_0800_0000, bus address of slot 0; slot stride is 1<<DDR_PAGE_SIZE_EXP.
- Derived constants: ENTRIES = ((1<<BLOCK_SIZE_EXP)>>DDR_PAGE_SIZE_EXP)-1 (15 by default); SLOT_W = clog2(LIST_SLOTS); IDX_W = DDR_PAGE_SIZE_EXP-3. Elaboration error if ENTRIES<1 or ENTRIES>(1<<IDX_W).

Ports:
- aclk  in  1  clock.
- aresetn  in  1  reset, synchronous, active-low.
- req_valid  in  1  transfer request valid.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_prp1  in  64  page-aligned block start address.
- fifo_empty  in  1  PRP FIFO head invalid.
- fifo_pop  out  1  consume FIFO head this cycle.
- data_from_fifo  in  DATA_WIDTH  FIFO head (show-ahead).
- list_wr_en  out  1  list RAM write strobe.
- list_wr_addr  out  SLOT_W+IDX_W  {slot, entry index}.
- list_wr_data  out  64  PRP entry.
- desc_valid  out  1  descriptor valid.
- desc_ready  in  1  descriptor accepted.
- desc_prp1  out  64  PRP1.
- desc_prp2  out  64  PRP2.
- desc_slot  out  SLOT_W  reserved slot id.
- slot_free  in  1  release pulse.
- slot_free_id  in  SLOT_W  slot to release.
- err_unaligned  out  1  sticky: a popped entry had nonzero page-offset bits.
- err_free  out  1  sticky: release of a non-busy slot.

Behaviour:
- Clocking and reset: single clock aclk; aresetn is synchronous, active-low. Reset forces state IDLE and clears the slot bitmap, both error flags and all registered outputs (list_wr_en, list_wr_*, desc_*) to 0. Reset mid-FILL or mid-DESC abandons the command; no partial descriptor is ever emitted.
- State IDLE:
  - req_ready = (state==IDLE) && (bitmap has a free bit).
  - On accept: latch req_prp1, allocate the lowest-numbered free slot (priority encoder), set its bitmap bit, clear idx, go to FILL.
- State FILL:
  - fifo_pop = (state==FILL) && !fifo_empty, combinational. No pop when empty; no pop outside FILL.
  - Each pop registers list_wr_en=1, list_wr_addr={slot,idx}, list_wr_data=data_from_fifo on the next cycle, then idx++.
  - On the pop with idx==ENTRIES-1, go to DESC.
  - ENTRIES==1: no list write; the popped entry itself becomes desc_prp2.
- State DESC:
  - desc_valid=1. desc_prp1=latched prp1. desc_prp2 = PRP_LIST_BASE + (slot << DDR_PAGE_SIZE_EXP), or the single entry when ENTRIES==1. desc_slot=slot.
  - Descriptor outputs hold stable until desc_ready; then IDLE.
  - desc_valid rises in the same cycle as the final list write.
- Latency (defaults, FIFO never empty): accept at cycle T0; pops T1..T15; writes T2..T16; desc_valid T16.
- Address check: any popped entry with bits [DDR_PAGE_SIZE_EXP-1:0] != 0 sets err_unaligned. The entry is still written.
- Slot release: slot_free with a busy id clears that bit.
  - Non-busy id: ignored, sets err_free.
  - Release and allocation in the same cycle: both apply. A released slot becomes allocatable on the next cycle (req_ready computed from the registered bitmap).
- Arithmetic: 64-bit unsigned, no overflow check on PRP_LIST_BASE + offset.

Decomposition:
- Package nvme_prp_pkg: ENTRIES/SLOT_W/IDX_W derivation functions, the state enum (IDLE, FILL, DESC), and the descriptor struct {prp1, prp2, slot}.
- One sub-module, prp_slot_alloc: owns the bitmap, lowest-free priority encoder, release logic and err_free.

Test Plan:
- Defaults, req_prp1=64'h10_0000_0000; FIFO supplies 64'h10_0000_1000..64'h10_0000_F000 continuously -> 15 writes at addr 0..14 with matching data; desc_valid at T16 with prp1=64'h10_0000_0000, prp2=64'h10_0800_0000, slot=0.
- fifo_empty toggled pseudo-randomly during FILL -> fifo_pop never high while empty; still exactly 15 writes, in order, no duplicates.
- Four back-to-back requests, no release -> slots 0..3 used, req_ready stays 0. Then slot_free id=2 -> next request gets slot 2, prp2=64'h10_0800_2000.
- desc_ready held 0 for 10 cycles -> desc_* stable, no pops, req_ready=0; desc_ready=1 -> IDLE next cycle.
- 5th popped entry = 64'h10_0000_5008 -> err_unaligned rises and stays 1; entry written unchanged. slot_free of idle slot 3 -> err_free=1, bitmap unchanged.
- aresetn=0 at the 7th pop -> all outputs 0, no descriptor. Next request gets slot 0, full 15-entry fill.
